// File: rtl/axi_uart_pkg.sv
// Shared types for the AXI-Lite to 16-bit SRAM bridge: FSM states, grant
// tracking and AXI response codes.
package axi_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_WRESP     = 3'd2,
    S_READ      = 3'd3,
    S_READ_WAIT = 3'd4,
    S_RRESP     = 3'd5
  } state_e;

  // Which transaction type won the most recent arbitration.
  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only full-halfword writes are accepted; partial strobes are rejected.
  function automatic logic strobe_ok(input logic [1:0] strb);
    return strb == 2'b11;
  endfunction

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI4-Lite channel bundle between a master and the SRAM bridge.
interface axil_sram_slave_if #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 20,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);

  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/sram_sp.sv
// Behavioural single-port SRAM with a one-cycle registered read, used beside
// the bridge at system level (not instantiated inside the bridge).
module sram_sp #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_n_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  // Write on active-low enable; read returns the pre-write contents next cycle.
  always_ff @(posedge clk_i) begin
    if (!we_n_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave bridging 32-bit AXI accesses onto a 16-bit single-port
// SRAM. One transaction in flight; simultaneous read/write requests are
// arbitrated round-robin. Only the low halfword of the data bus is stored.
module axil_sram_slave
  import axi_uart_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 20,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned MEMORY_ADDR_WIDTH  = 18,
  parameter int unsigned MEMORY_DATA_WIDTH  = 16
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  axil_sram_slave_if.slave             s_axi,
  output logic [MEMORY_ADDR_WIDTH-1:0] SRAM_address,
  output logic [MEMORY_DATA_WIDTH-1:0] SRAM_write_data,
  input  logic [MEMORY_DATA_WIDTH-1:0] SRAM_read_data,
  output logic                         SRAM_we_n
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned MA = MEMORY_ADDR_WIDTH;
  localparam int unsigned MD = MEMORY_DATA_WIDTH;

  state_e          state_q;
  grant_e          last_grant_q;
  logic            awready_q;
  logic            wready_q;
  logic            arready_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;
  logic [MA-1:0]   sram_addr_q;
  logic [MD-1:0]   sram_wdata_q;
  logic            sram_we_n_q;

  logic            wr_elig;
  logic            rd_elig;
  logic            grant_wr;
  logic            grant_rd;
  logic            aw_ok;
  logic            ar_ok;

  // Halfword-aligned and inside the SRAM window (all upper address bits zero).
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return (addr[0] == 1'b0) && ((addr >> (MA + 1)) == '0);
  endfunction

  // Request eligibility and round-robin arbitration; write wins ties when a
  // read was granted last.
  assign wr_elig  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_elig  = s_axi.S_AXI_ARVALID;
  assign grant_wr = wr_elig & (~rd_elig | (last_grant_q == GRANT_READ));
  assign grant_rd = rd_elig & ~grant_wr;

  assign aw_ok = addr_in_range(s_axi.S_AXI_AWADDR) & strobe_ok(s_axi.S_AXI_WSTRB[1:0]);
  assign ar_ok = addr_in_range(s_axi.S_AXI_ARADDR);

  // Transaction FSM: READY pulse, SRAM access, then hold response until accepted.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_READ;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_we_n_q  <= 1'b1;
    end else begin
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      sram_we_n_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (awready_q) begin
            // Write handshake completes this cycle; the payload is on the bus.
            if (aw_ok) begin
              sram_addr_q  <= s_axi.S_AXI_AWADDR[MA:1];
              sram_wdata_q <= s_axi.S_AXI_WDATA[MD-1:0];
              sram_we_n_q  <= 1'b0;
              state_q      <= S_WRITE;
            end else begin
              bvalid_q <= 1'b1;
              bresp_q  <= RESP_SLVERR;
              state_q  <= S_WRESP;
            end
          end else if (arready_q) begin
            if (ar_ok) begin
              sram_addr_q <= s_axi.S_AXI_ARADDR[MA:1];
              state_q     <= S_READ;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
              state_q  <= S_RRESP;
            end
          end else if (grant_wr) begin
            awready_q    <= 1'b1;
            wready_q     <= 1'b1;
            last_grant_q <= GRANT_WRITE;
          end else if (grant_rd) begin
            arready_q    <= 1'b1;
            last_grant_q <= GRANT_READ;
          end
        end
        S_WRITE: begin
          bvalid_q <= 1'b1;
          bresp_q  <= RESP_OKAY;
          state_q  <= S_WRESP;
        end
        S_WRESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_READ: begin
          state_q <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          rdata_q  <= DW'(SRAM_read_data);
          rvalid_q <= 1'b1;
          rresp_q  <= RESP_OKAY;
          state_q  <= S_RRESP;
        end
        S_RRESP: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = sram_wdata_q;
  assign SRAM_we_n       = sram_we_n_q;

  // Upper data lanes and strobes are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_WDATA[DW-1:MD], s_axi.S_AXI_WSTRB[DW/8-1:2]};

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed plus randomized bench for axil_sram_slave with a behavioural
// SRAM beside it and an associative-array memory model as reference.
module tb_axil_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;

  logic [15:0] model [int unsigned];

  axil_sram_slave_if #(.C_S_AXI_ADDR_WIDTH(20), .C_S_AXI_DATA_WIDTH(32)) bus ();

  axil_sram_slave #(
    .C_S_AXI_ADDR_WIDTH(20), .C_S_AXI_DATA_WIDTH(32),
    .MEMORY_ADDR_WIDTH(18),  .MEMORY_DATA_WIDTH(16)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi(bus),
    .SRAM_address(sram_addr),
    .SRAM_write_data(sram_wdata),
    .SRAM_read_data(sram_rdata),
    .SRAM_we_n(sram_we_n)
  );

  sram_sp #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) u_sram (
    .clk_i(clk), .addr_i(sram_addr), .wdata_i(sram_wdata),
    .we_n_i(sram_we_n), .rdata_o(sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: even address below 2^19 bytes.
  function automatic logic addr_ok_m(input logic [19:0] a);
    return (a % 2 == 0) && (a < 20'h80000);
  endfunction

  task automatic do_reset(input string tag);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;  bus.S_AXI_RREADY = 1'b1;
    rst_n = 1'b0;
    #1;
    chk({tag, " awready"}, 32'(bus.S_AXI_AWREADY), 0);
    chk({tag, " wready"},  32'(bus.S_AXI_WREADY), 0);
    chk({tag, " arready"}, 32'(bus.S_AXI_ARREADY), 0);
    chk({tag, " bvalid"},  32'(bus.S_AXI_BVALID), 0);
    chk({tag, " rvalid"},  32'(bus.S_AXI_RVALID), 0);
    chk({tag, " bresp/rresp"}, 32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 0);
    chk({tag, " rdata"},   bus.S_AXI_RDATA, 0);
    chk({tag, " sram addr"}, 32'(sram_addr), 0);
    chk({tag, " sram wdata"}, 32'(sram_wdata), 0);
    chk({tag, " sram we_n"}, 32'(sram_we_n), 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic axi_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                           input string tag);
    logic ok;
    int t_hs, t_b, we_cnt, we_t;
    logic [17:0] wa;
    logic [15:0] wd;
    logic [1:0]  resp;
    ok = addr_ok_m(a) && (s[1:0] == 2'b11);
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    t_hs = -1; t_b = -1; we_cnt = 0; we_t = -1; wa = '0; wd = '0; resp = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.S_AXI_AWREADY) begin t_hs = cyc; break; end
    end
    chk({tag, " aw handshake"}, 32'(t_hs >= 0), 1);
    chk({tag, " wready with awready"}, 32'(bus.S_AXI_WREADY), 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        chk({tag, " awready one cycle"}, 32'(bus.S_AXI_AWREADY), 0);
      end
      if (!sram_we_n) begin we_cnt++; we_t = cyc; wa = sram_addr; wd = sram_wdata; end
      if (bus.S_AXI_BVALID) begin t_b = cyc; resp = bus.S_AXI_BRESP; break; end
    end
    chk({tag, " bvalid latency"}, 32'(t_b - t_hs), ok ? 2 : 1);
    chk({tag, " bresp"}, 32'(resp), ok ? 0 : 2);
    chk({tag, " we_n low cycles"}, 32'(we_cnt), ok ? 1 : 0);
    if (ok) begin
      chk({tag, " we_n at T+1"}, 32'(we_t - t_hs), 1);
      chk({tag, " sram address"}, 32'(wa), 32'(a >> 1));
      chk({tag, " sram data"}, 32'(wd), d % 65536);
      model[int'(a >> 1)] = d[15:0];
    end
    tick();
    chk({tag, " bvalid dropped"}, 32'(bus.S_AXI_BVALID), 0);
  endtask

  task automatic axi_read(input logic [19:0] a, input int hold, input string tag);
    logic ok, known;
    logic [31:0] exp_d, got_d;
    logic [1:0]  got_resp;
    int t_hs, t_r, h;
    ok = addr_ok_m(a);
    known = !ok;
    exp_d = 32'h0;
    if (ok && model.exists(int'(a >> 1))) begin
      known = 1'b1;
      exp_d = 32'(model[int'(a >> 1)]);
    end
    h = known ? hold : 0;
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = (h == 0);
    t_hs = -1; t_r = -1; got_d = '0; got_resp = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.S_AXI_ARREADY) begin t_hs = cyc; break; end
    end
    chk({tag, " ar handshake"}, 32'(t_hs >= 0), 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        bus.S_AXI_ARVALID = 1'b0;
        chk({tag, " arready one cycle"}, 32'(bus.S_AXI_ARREADY), 0);
      end
      if (bus.S_AXI_RVALID) begin
        t_r = cyc; got_d = bus.S_AXI_RDATA; got_resp = bus.S_AXI_RRESP; break;
      end
    end
    chk({tag, " rvalid latency"}, 32'(t_r - t_hs), ok ? 3 : 1);
    chk({tag, " rresp"}, 32'(got_resp), ok ? 0 : 2);
    if (known) chk({tag, " rdata"}, got_d, exp_d);
    for (int i = 0; i < h; i++) begin
      tick();
      chk({tag, " rvalid held"}, 32'(bus.S_AXI_RVALID), 1);
      chk({tag, " rdata held"}, bus.S_AXI_RDATA, exp_d);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    chk({tag, " rvalid dropped"}, 32'(bus.S_AXI_RVALID), 0);
  endtask

  // AW, W and AR raised together on the same halfword; checks who wins and
  // that the read sees data consistent with that order.
  task automatic tie_round(input logic [19:0] a, input logic [31:0] d,
                           input logic exp_wr_first, input string tag);
    int first, both;
    logic got_r, got_b, clr_w, clr_r;
    logic [31:0] rd, exp_rd;
    exp_rd = model.exists(int'(a >> 1)) ? 32'(model[int'(a >> 1)]) : 32'h0;
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_ARADDR = a;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    first = 0; both = 0; got_r = 1'b0; got_b = 1'b0; clr_w = 1'b0; clr_r = 1'b0; rd = '1;
    for (int k = 0; k < 80 && !(got_r && got_b); k++) begin
      tick();
      if (clr_w) begin bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; clr_w = 1'b0; end
      if (clr_r) begin bus.S_AXI_ARVALID = 1'b0; clr_r = 1'b0; end
      if (bus.S_AXI_AWREADY && bus.S_AXI_ARREADY) both++;
      if (bus.S_AXI_AWREADY) begin if (first == 0) first = 1; clr_w = 1'b1; end
      if (bus.S_AXI_ARREADY) begin if (first == 0) first = 2; clr_r = 1'b1; end
      if (bus.S_AXI_RVALID) begin got_r = 1'b1; rd = bus.S_AXI_RDATA; end
      if (bus.S_AXI_BVALID) got_b = 1'b1;
    end
    tick();
    chk({tag, " first grant"}, 32'(first), exp_wr_first ? 1 : 2);
    chk({tag, " readies exclusive"}, 32'(both), 0);
    chk({tag, " both responses"}, 32'({got_r, got_b}), 3);
    chk({tag, " read data"}, rd, (first == 1) ? 32'(d[15:0]) : exp_rd);
    model[int'(a >> 1)] = d[15:0];
  endtask

  initial begin
    int t_hs, bv_cnt, sel, hold;
    logic [19:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    tick();
    do_reset("reset");

    axi_write(20'h00010, 32'h0000BEEF, 4'hF, "wr beef");
    axi_read(20'h00010, 5, "rd beef");
    axi_write(20'h80000, 32'h12345678, 4'hF, "wr out of range");
    axi_write(20'h00011, 32'h12345678, 4'hF, "wr odd");
    axi_write(20'h00012, 32'h0000AAAA, 4'b1101, "wr bad strobe");
    axi_read(20'h80010, 0, "rd out of range");
    axi_read(20'h00013, 2, "rd odd");
    axi_write(20'h00014, 32'hFFFF5A5A, 4'b0011, "wr upper ignored");
    axi_read(20'h00014, 1, "rd upper ignored");
    axi_write(20'h7FFFE, 32'h0000C0DE, 4'hF, "wr top halfword");
    axi_read(20'h7FFFE, 0, "rd top halfword");

    do_reset("reset 2");
    tie_round(20'h00040, 32'h00001111, 1'b1, "tie 1");
    tie_round(20'h00040, 32'h00002222, 1'b1, "tie 2");
    axi_write(20'h00044, 32'h00003333, 4'hF, "wr before tie");
    tie_round(20'h00044, 32'h00004444, 1'b0, "tie 3");

    // Reset while the SRAM write strobe is active.
    bus.S_AXI_AWADDR = 20'h00020; bus.S_AXI_WDATA = 32'h00009999; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    t_hs = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.S_AXI_AWREADY) begin t_hs = cyc; break; end
    end
    chk("abort aw handshake", 32'(t_hs >= 0), 1);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("abort we_n low in write", 32'(sram_we_n), 0);
    rst_n = 1'b0;
    #1;
    chk("abort we_n async high", 32'(sram_we_n), 1);
    chk("abort sram addr cleared", 32'(sram_addr), 0);
    tick(); tick();
    rst_n = 1'b1;
    bv_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.S_AXI_BVALID || !sram_we_n) bv_cnt++;
    end
    chk("abort no response", 32'(bv_cnt), 0);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      a = 20'(32'h100 + 2 * $urandom_range(0, 7));
      if (sel == 8) a = a + 20'h1;
      if (sel == 9) a = a + 20'h80000;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) s[1:0] = 2'b11;
      hold = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) axi_write(a, d, s, $sformatf("rnd wr %0d", n));
      else axi_read(a, hold, $sformatf("rnd rd %0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axil_sram_slave.md
AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 20, AXI byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width.
REQ-003 SHALL have parameter MEMORY_ADDR_WIDTH, default 18, SRAM halfword-address width.
REQ-004 SHALL have parameter MEMORY_DATA_WIDTH, default 16, SRAM word width.
REQ-005 SHALL have port S_AXI_ACLK  in  1  sole clock; one clock, all logic on rising edge.
REQ-006 SHALL have port S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address.
REQ-008 SHALL have port S_AXI_AWVALID  in  1  write address valid.
REQ-009 SHALL have port S_AXI_AWREADY  out  1  write address accepted.
REQ-010 SHALL have port S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
REQ-011 SHALL have port S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
REQ-012 SHALL have port S_AXI_WVALID  in  1  write data valid.
REQ-013 SHALL have port S_AXI_WREADY  out  1  write data accepted.
REQ-014 SHALL have port S_AXI_BRESP  out  2  write response.
REQ-015 SHALL have port S_AXI_BVALID  out  1  write response valid.
REQ-016 SHALL have port S_AXI_BREADY  in  1  master accepts response.
REQ-017 SHALL have port S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address.
REQ-018 SHALL have port S_AXI_ARVALID  in  1  read address valid.
REQ-019 SHALL have port S_AXI_ARREADY  out  1  read address accepted.
REQ-020 SHALL have port S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
REQ-021 SHALL have port S_AXI_RRESP  out  2  read response.
REQ-022 SHALL have port S_AXI_RVALID  out  1  read data valid.
REQ-023 SHALL have port S_AXI_RREADY  in  1  master accepts read data.
REQ-024 SHALL have port SRAM_address  out  MEMORY_ADDR_WIDTH  halfword address.
REQ-025 SHALL have port SRAM_write_data  out  MEMORY_DATA_WIDTH  write data.
REQ-026 SHALL have port SRAM_read_data  in  MEMORY_DATA_WIDTH  read data, valid one cycle after address.
REQ-027 SHALL have port SRAM_we_n  out  1  write enable, active-low.

Function
REQ-028 States SHALL be S_IDLE, S_WRITE, S_WRESP, S_READ, S_READ_WAIT, S_RRESP; one transaction in flight.
REQ-029 In S_IDLE, write pair SHALL be eligible only when AWVALID and WVALID both high; AWREADY and WREADY SHALL pulse together for exactly one cycle (T).
REQ-030 In S_IDLE, read SHALL be eligible when ARVALID high; ARREADY SHALL pulse one cycle (T).
REQ-031 Write and read eligible same cycle: grant SHALL go to the type not granted last (last_grant register); after reset, write wins.
REQ-032 Address valid iff addr[0]==0 and addr[C_S_AXI_ADDR_WIDTH-1:MEMORY_ADDR_WIDTH+1]==0; write additionally requires WSTRB[1:0]==2'b11; WSTRB[3:2] and WDATA[31:16] ignored.
REQ-033 Valid write: SRAM_address=AWADDR[MEMORY_ADDR_WIDTH:1], SRAM_write_data=WDATA[15:0], SRAM_we_n low exactly at T+1 (S_WRITE); BVALID high from T+2, BRESP=2'b00.
REQ-034 Valid read: SRAM_address=ARADDR[MEMORY_ADDR_WIDTH:1] at T+1 (S_READ), SRAM_read_data captured at T+2 (S_READ_WAIT), RVALID from T+3 with RDATA={16'h0000,data}, RRESP=2'b00.
REQ-035 Invalid request: no SRAM access (SRAM_we_n stays high), BVALID/RVALID from T+1, response 2'b10 (SLVERR), RDATA=0.
REQ-036 BVALID/RVALID and their payloads SHALL hold stable until BREADY/RREADY high; return to S_IDLE the following cycle; no new READY pulse while a response is pending.
REQ-037 SRAM_we_n SHALL be high in every state except S_WRITE.

Reset
REQ-038 On ARESETN low (any state, mid-transaction): state S_IDLE, all READY/VALID low, BRESP/RRESP/RDATA 0, SRAM_address/SRAM_write_data 0, SRAM_we_n 1, last_grant = read, immediately (asynchronous).
REQ-039 Transaction aborted by reset SHALL produce no response after release.

Structure
REQ-040 State enum and response codes (OKAY 2'b00, SLVERR 2'b10) SHALL live in shared package axi_uart_pkg.
REQ-041 Single sub-module sram_sp (behavioural single-port 2^18 x 16 RAM, 1-cycle read) SHALL be used only in the bench/top level, not inside this block.

Verification
REQ-042 Write 0x00010 data 0x0000BEEF strobe 4'hF -> SRAM_we_n low one cycle, address 0x00008, data 0xBEEF; BRESP 00 at T+2.
REQ-043 Read 0x00010 after above -> RVALID at T+3, RDATA 0x0000BEEF, RRESP 00; RREADY held low 5 cycles -> RVALID/RDATA stable.
REQ-044 Write 0x80000 (out of range) and write 0x00011 (odd) -> BRESP 10 at T+1, SRAM_we_n never low.
REQ-045 AW, W, AR all valid same cycle from reset -> write granted first, read next; repeat -> grants alternate.
REQ-046 Assert ARESETN low during S_WRITE -> SRAM_we_n high same cycle, no BVALID after release.
